pcm_to_i2s: RTL and testbench

Stereo I2S transmitter, the output-side counterpart of the beamformer's I2S receive path. It accepts parallel left/right PCM sample pairs through a valid/ready handshake and serializes them MSB-first in standard I2S framing. It is the I2S master: it generates WS from the system clock, and the system clock is the bit clock. It drives a downstream codec or a loopback into the receive path.

---
 rtl/pcm_to_i2s_pkg.sv | 12 +
 rtl/pcm_holding_register.sv | 54 +++++
 rtl/pcm_to_i2s.sv | 153 +++++++++++++++
 tb/tb_pcm_to_i2s.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_to_i2s_pkg.sv
// Shared constants and state encoding for the PCM-to-I2S transmitter.
package pcm_to_i2s_pkg;

  localparam int unsigned DEFAULT_NUMBER_OF_BITS = 8;
  localparam int unsigned DEFAULT_SLOT_BITS      = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pcm_holding_register.sv
// Single-entry stereo holding register with valid/ready intake and a frame-load drain.
module pcm_holding_register
  import pcm_to_i2s_pkg::*;
#(
  parameter int unsigned NUMBER_OF_BITS = DEFAULT_NUMBER_OF_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUMBER_OF_BITS-1:0] in_left,
  input  logic [NUMBER_OF_BITS-1:0] in_right,
  input  logic                      in_valid,
  output logic                      in_ready_c,
  input  logic                      load_i,
  output logic                      full_o,
  output logic [NUMBER_OF_BITS-1:0] left_o,
  output logic [NUMBER_OF_BITS-1:0] right_o
);

  logic                      full_q,  full_d;
  logic [NUMBER_OF_BITS-1:0] left_q,  left_d;
  logic [NUMBER_OF_BITS-1:0] right_q, right_d;

  assign in_ready_c = !full_q;
  assign full_o     = full_q;
  assign left_o     = left_q;
  assign right_o    = right_q;

  // A load empties a full register; an empty register may accept even on a load edge.
  always_comb begin
    full_d  = full_q;
    left_d  = left_q;
    right_d = right_q;
    if (load_i && full_q) begin
      full_d = 1'b0;
    end else if (in_valid && !full_q) begin
      full_d  = 1'b1;
      left_d  = in_left;
      right_d = in_right;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      full_q  <= full_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

endmodule

// File: rtl/pcm_to_i2s.sv
// I2S master transmitter: frames held PCM pairs into MSB-first slots with the one-bit WS delay.
module pcm_to_i2s
  import pcm_to_i2s_pkg::*;
#(
  parameter int unsigned NUMBER_OF_BITS = DEFAULT_NUMBER_OF_BITS,
  parameter int unsigned SLOT_BITS      = DEFAULT_SLOT_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUMBER_OF_BITS-1:0] sample_left,
  input  logic [NUMBER_OF_BITS-1:0] sample_right,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic                      ws,
  output logic                      sd,
  output logic                      frame_start,
  output logic                      underrun
);

  localparam int unsigned PW  = $clog2(2 * SLOT_BITS);
  localparam int unsigned CW  = $clog2(SLOT_BITS);
  localparam int unsigned PAD = SLOT_BITS - NUMBER_OF_BITS;

  localparam logic [PW-1:0] P_LAST = PW'(2 * SLOT_BITS - 1);
  localparam logic [PW-1:0] P_SLOT = PW'(SLOT_BITS);

  state_e                    state_q, state_d;
  logic [PW-1:0]             p_q, p_d;
  logic [NUMBER_OF_BITS-1:0] tx_l_q, tx_l_d;
  logic [NUMBER_OF_BITS-1:0] tx_r_q, tx_r_d;
  logic                      ws_q, ws_d;
  logic                      sd_q, sd_d;
  logic                      frame_start_q, frame_start_d;
  logic                      underrun_q, underrun_d;

  logic                      load_c;
  logic                      hold_full;
  logic [NUMBER_OF_BITS-1:0] hold_l;
  logic [NUMBER_OF_BITS-1:0] hold_r;

  logic                      right_slot;
  logic [CW-1:0]             slot_pos;
  logic [CW-1:0]             bit_idx;
  logic [SLOT_BITS-1:0]      word_l;
  logic [SLOT_BITS-1:0]      word_r;
  logic                      line_bit;

  pcm_holding_register #(
    .NUMBER_OF_BITS (NUMBER_OF_BITS)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_left    (sample_left),
    .in_right   (sample_right),
    .in_valid   (sample_valid),
    .in_ready_c (sample_ready),
    .load_i     (load_c),
    .full_o     (hold_full),
    .left_o     (hold_l),
    .right_o    (hold_r)
  );

  // Slot words are left-justified; slot position 0 replays the previous slot's LSB.
  always_comb begin
    word_l     = SLOT_BITS'(tx_l_q) << PAD;
    word_r     = SLOT_BITS'(tx_r_q) << PAD;
    right_slot = (p_q >= P_SLOT);
    slot_pos   = CW'(right_slot ? (p_q - P_SLOT) : p_q);
    bit_idx    = CW'(SLOT_BITS) - slot_pos;
    if (slot_pos == '0) begin
      line_bit = right_slot ? word_l[0] : word_r[0];
    end else begin
      line_bit = right_slot ? word_r[bit_idx] : word_l[bit_idx];
    end
  end

  always_comb begin
    state_d       = state_q;
    p_d           = p_q;
    tx_l_d        = tx_l_q;
    tx_r_d        = tx_r_q;
    ws_d          = 1'b0;
    sd_d          = 1'b0;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    load_c        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        p_d = '0;
        if (enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        ws_d = right_slot;
        sd_d = line_bit;
        if (p_q == '0) begin
          frame_start_d = 1'b1;
          load_c        = 1'b1;
          if (hold_full) begin
            tx_l_d = hold_l;
            tx_r_d = hold_r;
          end else begin
            tx_l_d     = '0;
            tx_r_d     = '0;
            underrun_d = 1'b1;
          end
        end
        if (p_q == P_LAST) begin
          p_d = '0;
          // Clearing the line data makes the next run start with a zero replay bit.
          if (!enable) begin
            state_d = ST_IDLE;
            tx_l_d  = '0;
            tx_r_d  = '0;
          end
        end else begin
          p_d = p_q + PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      p_q           <= '0;
      tx_l_q        <= '0;
      tx_r_q        <= '0;
      ws_q          <= 1'b0;
      sd_q          <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      tx_l_q        <= tx_l_d;
      tx_r_q        <= tx_r_d;
      ws_q          <= ws_d;
      sd_q          <= sd_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign ws          = ws_q;
  assign sd          = sd_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_pcm_to_i2s.sv
// Self-checking bench for pcm_to_i2s: 16-bit-slot instance plus an unpadded 8-bit-slot instance.
module tb_pcm_to_i2s;

  logic clk;
  logic rst_n;

  logic       m_en, m_valid, m_ready, m_ws, m_sd, m_fs, m_ur;
  logic [7:0] m_l, m_r;
  logic       n_en, n_valid, n_ready, n_ws, n_sd, n_fs, n_ur;
  logic [7:0] n_l, n_r;

  int total;
  int bad;
  bit prev_m;
  bit prev_n;

  pcm_to_i2s #(.NUMBER_OF_BITS(8), .SLOT_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(m_en),
    .sample_left(m_l), .sample_right(m_r), .sample_valid(m_valid), .sample_ready(m_ready),
    .ws(m_ws), .sd(m_sd), .frame_start(m_fs), .underrun(m_ur)
  );

  pcm_to_i2s #(.NUMBER_OF_BITS(8), .SLOT_BITS(8)) dut_np (
    .clk(clk), .rst_n(rst_n), .enable(n_en),
    .sample_left(n_l), .sample_right(n_r), .sample_valid(n_valid), .sample_ready(n_ready),
    .ws(n_ws), .sd(n_sd), .frame_start(n_fs), .underrun(n_ur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial stream of one frame without the I2S delay: left word then right word, MSB first.
  function automatic bit stream_bit(int s, logic [7:0] l, logic [7:0] r, int j);
    int unsigned w;
    int          k;
    if (j < s) begin
      w = 32'(l) << (s - 8);
      k = s - 1 - j;
    end else begin
      w = 32'(r) << (s - 8);
      k = s - 1 - (j - s);
    end
    return w[k];
  endfunction

  // Line bit at frame position p is the stream delayed by one bit clock.
  function automatic bit model_sd(int s, logic [7:0] l, logic [7:0] r, int p, bit prev);
    return (p == 0) ? prev : stream_bit(s, l, r, p - 1);
  endfunction

  task automatic test_reset();
    logic [4:0] obs;
    rst_n = 1'b0;
    #22 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    obs = {m_ws, m_sd, m_fs, m_ur, m_ready};
    total++;
    if (obs !== 5'b00001) begin
      bad++;
      $display("FAIL reset_main got=%b want=00001", obs);
    end
    obs = {n_ws, n_sd, n_fs, n_ur, n_ready};
    total++;
    if (obs !== 5'b00001) begin
      bad++;
      $display("FAIL reset_np got=%b want=00001", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_m = 1'b0;
    prev_n = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    logic [3:0] obs, want;
    @(negedge clk);
    total++;
    if (m_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_ready_idle got=%b want=1", m_ready);
    end
    m_l = 8'hA5; m_r = 8'h3C; m_valid = 1'b1;
    @(negedge clk);
    m_valid = 1'b0;
    total++;
    if (m_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_ready_held got=%b want=0", m_ready);
    end
    m_en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (m_fs !== 1'b1 && n < 40);
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL basic_start_latency got=%0d want=2", n);
    end
    for (int p = 0; p < 32; p++) begin
      if (p > 0) @(negedge clk);
      obs  = {m_ws, m_sd, m_fs, m_ur};
      want = {(p >= 16), model_sd(16, 8'hA5, 8'h3C, p, prev_m), (p == 0), 1'b0};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL basic_frame p=%0d got=%b want=%b", p, obs, want);
      end
    end
    prev_m = stream_bit(16, 8'hA5, 8'h3C, 31);
  endtask

  task automatic test_underrun();
    logic [3:0] obs, want;
    for (int p = 0; p < 32; p++) begin
      @(negedge clk);
      obs  = {m_ws, m_sd, m_fs, m_ur};
      want = {(p >= 16), model_sd(16, 8'h00, 8'h00, p, prev_m), (p == 0), (p == 0)};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL underrun_frame p=%0d got=%b want=%b", p, obs, want);
      end
    end
    prev_m = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] fl [3];
    logic [7:0] fr [3];
    bit         fu [3];
    logic [3:0] obs, want;
    int f, p;
    fl[0] = 8'h00; fr[0] = 8'h00; fu[0] = 1'b1;
    for (int i = 1; i < 3; i++) begin
      fl[i] = 8'($urandom); fr[i] = 8'($urandom); fu[i] = 1'b0;
    end
    for (int g = 0; g < 96; g++) begin
      @(negedge clk);
      f = g / 32;
      p = g % 32;
      obs  = {m_ws, m_sd, m_fs, m_ur};
      want = {(p >= 16), model_sd(16, fl[f], fr[f], p, prev_m), (p == 0), (p == 0) && fu[f]};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL b2b_frame f=%0d p=%0d got=%b want=%b", f, p, obs, want);
      end
      if (p == 31) prev_m = stream_bit(16, fl[f], fr[f], 31);
      if (g >= 5 && g <= 31 || g == 33) begin
        total++;
        if (m_ready !== 1'b0) begin
          bad++;
          $display("FAIL b2b_ready_low g=%0d got=%b want=0", g, m_ready);
        end
      end
      if (g == 32) begin
        total++;
        if (m_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready_rise got=%b want=1", m_ready);
        end
      end
      if (g == 4) begin m_l = fl[1]; m_r = fr[1]; m_valid = 1'b1; end
      if (g == 5) begin m_l = fl[2]; m_r = fr[2]; end
      if (g == 33) m_valid = 1'b0;
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] fl [2];
    logic [7:0] fr [2];
    logic [3:0] obs, want;
    int f, p;
    fl[0] = 8'h00; fr[0] = 8'h00;
    fl[1] = 8'($urandom); fr[1] = 8'($urandom);
    for (int g = 0; g < 64; g++) begin
      @(negedge clk);
      f = g / 32;
      p = g % 32;
      obs  = {m_ws, m_sd, m_fs, m_ur};
      want = {(p >= 16), model_sd(16, fl[f], fr[f], p, prev_m), (p == 0), (p == 0) && (f == 0)};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL drop_frame f=%0d p=%0d got=%b want=%b", f, p, obs, want);
      end
      if (p == 31) prev_m = stream_bit(16, fl[f], fr[f], 31);
      if (g == 8) begin m_l = fl[1]; m_r = fr[1]; m_valid = 1'b1; end
      if (g == 9) m_valid = 1'b0;
      if (g == 37) m_en = 1'b0;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      obs = {m_ws, m_sd, m_fs, m_ur};
      total++;
      if (obs !== 4'b0000 || m_ready !== 1'b1) begin
        bad++;
        $display("FAIL drop_idle i=%0d got=%b ready=%b want=0000 ready=1", i, obs, m_ready);
      end
    end
    prev_m = 1'b0;
  endtask

  task automatic test_midframe_reset();
    logic [7:0] l4, r4;
    logic [3:0] obs, want;
    logic [4:0] obs5;
    int n;
    l4 = 8'($urandom); r4 = 8'($urandom);
    @(negedge clk);
    m_l = l4; m_r = r4; m_valid = 1'b1; m_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      m_valid = 1'b0;
      n++;
    end while (m_fs !== 1'b1 && n < 40);
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL mreset_start_latency got=%0d want=2", n);
    end
    for (int p = 0; p <= 20; p++) begin
      if (p > 0) @(negedge clk);
      obs  = {m_ws, m_sd, m_fs, m_ur};
      want = {(p >= 16), model_sd(16, l4, r4, p, 1'b0), (p == 0), 1'b0};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL mreset_pre p=%0d got=%b want=%b", p, obs, want);
      end
      if (p == 10) begin m_l = 8'($urandom); m_r = 8'($urandom); m_valid = 1'b1; end
      if (p == 11) m_valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    obs5 = {m_ws, m_sd, m_fs, m_ur, m_ready};
    total++;
    if (obs5 !== 5'b00001) begin
      bad++;
      $display("FAIL mreset_async got=%b want=00001", obs5);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (m_fs !== 1'b1 && n < 40);
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL mreset_restart_latency got=%0d want=2", n);
    end
    for (int p = 0; p < 32; p++) begin
      if (p > 0) @(negedge clk);
      obs  = {m_ws, m_sd, m_fs, m_ur};
      want = {(p >= 16), 1'b0, (p == 0), (p == 0)};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL mreset_post p=%0d got=%b want=%b", p, obs, want);
      end
      if (p == 3) m_en = 1'b0;
    end
  endtask

  task automatic test_no_padding();
    logic [7:0] rr;
    logic [3:0] obs, want;
    int n;
    rr = 8'($urandom) | 8'h01;
    @(negedge clk);
    n_l = 8'h81; n_r = rr; n_valid = 1'b1; n_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n_valid = 1'b0;
      n++;
    end while (n_fs !== 1'b1 && n < 40);
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL nopad_start_latency got=%0d want=2", n);
    end
    for (int p = 0; p < 16; p++) begin
      if (p > 0) @(negedge clk);
      obs  = {n_ws, n_sd, n_fs, n_ur};
      want = {(p >= 8), model_sd(8, 8'h81, rr, p, prev_n), (p == 0), 1'b0};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL nopad_frame p=%0d got=%b want=%b", p, obs, want);
      end
    end
    prev_n = stream_bit(8, 8'h81, rr, 15);
    for (int p = 0; p < 16; p++) begin
      @(negedge clk);
      obs  = {n_ws, n_sd, n_fs, n_ur};
      want = {(p >= 8), model_sd(8, 8'h00, 8'h00, p, prev_n), (p == 0), (p == 0)};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL nopad_under p=%0d got=%b want=%b", p, obs, want);
      end
      if (p == 2) n_en = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      obs = {n_ws, n_sd, n_fs, n_ur};
      total++;
      if (obs !== 4'b0000) begin
        bad++;
        $display("FAIL nopad_idle i=%0d got=%b want=0000", i, obs);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    m_en = 1'b0; m_valid = 1'b0; m_l = '0; m_r = '0;
    n_en = 1'b0; n_valid = 1'b0; n_l = '0; n_r = '0;
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_enable_drop();
    test_midframe_reset();
    test_no_padding();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
